// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_stage
// Description : Two-entry, in-order result buffer between the ALU and the
//               register-file writeback. Each accepted ALU result (data byte,
//               destination index, write enable) is held until writeback
//               consumes it. The stage also owns the architectural carry flag
//               (fed back to the ALU as the ADDC carry-in) and the zero flag
//               of the most recently accepted result.
//
// Ports       : clk        - single clock, all state on the rising edge
//               reset      - synchronous, active-high reset
//               in_valid   - ALU result present this cycle
//               in_ready   - stage can accept a result (registered state only)
//               alu_out    - ALU result byte
//               alu_zero   - ALU zero flag
//               alu_cout   - ALU carry-out
//               carry_we   - instruction updates the carry flag
//               rd         - destination register index
//               rd_we      - instruction writes rd
//               carry_q    - architectural carry flag
//               zero_q     - zero flag of the last accepted result
//               out_valid  - head entry available to writeback
//               out_ready  - writeback consumes the head entry
//               out_data   - head entry data   (0 when empty)
//               out_rd     - head entry rd     (0 when empty)
//               out_we     - head entry we     (0 when empty)
//
// Option      : ALU_RESULT_FWD_EN - when defined, adds fwd_valid / fwd_rd /
//               fwd_data, presenting the youngest held entry that writes a
//               register so the operand stage can bypass from it.
//
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_stage (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] alu_out,
    input  logic       alu_zero,
    input  logic       alu_cout,
    input  logic       carry_we,
    input  logic [2:0] rd,
    input  logic       rd_we,
    output logic       carry_q,
    output logic       zero_q,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [2:0] out_rd,
    output logic       out_we
`ifdef ALU_RESULT_FWD_EN
    ,
    output logic       fwd_valid,
    output logic [2:0] fwd_rd,
    output logic [7:0] fwd_data
`endif
);

    localparam logic [1:0] c_COUNT_EMPTY = 2'd0;
    localparam logic [1:0] c_COUNT_FULL  = 2'd2;

    // ------------------------------------------------------------------
    // Storage and bookkeeping
    // ------------------------------------------------------------------
    logic [7:0] r_data [2];
    logic [2:0] r_rd   [2];
    logic       r_we   [2];

    logic       r_wr_ptr;   // slot the next accepted result goes into
    logic       r_rd_ptr;   // slot of the oldest held result
    logic [1:0] r_count;    // number of held results, 0..2
    logic       r_carry;
    logic       r_zero;

    logic       w_push;
    logic       w_pop;
    logic       w_empty;
    logic [1:0] w_count_nxt;

    // Both handshakes depend only on registered occupancy, so there is no
    // combinational path from out_ready to in_ready nor from in_* to out_*.
    assign w_empty   = (r_count == c_COUNT_EMPTY);
    assign in_ready  = (r_count < c_COUNT_FULL);
    assign out_valid = !w_empty;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    // Push and pop together leave occupancy unchanged; the pointers still
    // advance, so at count 1 the freshly written slot becomes the head.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= c_COUNT_EMPTY;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_data[i] <= 8'h00;
                r_rd[i]   <= 3'd0;
                r_we[i]   <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_data[r_wr_ptr] <= alu_out;
                r_rd[r_wr_ptr]   <= rd;
                r_we[r_wr_ptr]   <= rd_we;
                r_wr_ptr         <= ~r_wr_ptr;
                // Zero flag tracks every accepted result, even ones that
                // do not write a register (compares, tests).
                r_zero           <= alu_zero;
                if (carry_we) begin
                    r_carry <= alu_cout;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_nxt;
        end
    end

    assign carry_q = r_carry;
    assign zero_q  = r_zero;

    // ------------------------------------------------------------------
    // Head presentation: forced to zero when nothing is held so writeback
    // never sees stale slot contents.
    // ------------------------------------------------------------------
    always_comb begin
        out_data = 8'h00;
        out_rd   = 3'd0;
        out_we   = 1'b0;
        if (!w_empty) begin
            out_data = r_data[r_rd_ptr];
            out_rd   = r_rd[r_rd_ptr];
            out_we   = r_we[r_rd_ptr];
        end
    end

`ifdef ALU_RESULT_FWD_EN
    // ------------------------------------------------------------------
    // Forwarding: the youngest held entry always sits just behind the
    // write pointer. When two entries are held and the youngest does not
    // write a register, fall back to the older (head) entry.
    // ------------------------------------------------------------------
    logic w_young;
    assign w_young = ~r_wr_ptr;

    always_comb begin
        fwd_valid = 1'b0;
        fwd_rd    = 3'd0;
        fwd_data  = 8'h00;
        if (!w_empty && r_we[w_young]) begin
            fwd_valid = 1'b1;
            fwd_rd    = r_rd[w_young];
            fwd_data  = r_data[w_young];
        end else if ((r_count == c_COUNT_FULL) && r_we[r_rd_ptr]) begin
            fwd_valid = 1'b1;
            fwd_rd    = r_rd[r_rd_ptr];
            fwd_data  = r_data[r_rd_ptr];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_result_stage
// Description : Scoreboard bench for alu_result_stage. A driver issues
//               directed then randomized cycles, keeps a queue-based model
//               of the held results and flags, and pushes each accepted
//               result into a scoreboard. A separate monitor pops and
//               compares whenever writeback consumes the head entry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_stage;

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] r;
        logic       w;
    } ent_t;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] alu_out;
    logic       alu_zero;
    logic       alu_cout;
    logic       carry_we;
    logic [2:0] rd;
    logic       rd_we;
    logic       carry_q;
    logic       zero_q;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_rd;
    logic       out_we;
`ifdef ALU_RESULT_FWD_EN
    logic       fwd_valid;
    logic [2:0] fwd_rd;
    logic [7:0] fwd_data;
`endif

    alu_result_stage dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_out   (alu_out),
        .alu_zero  (alu_zero),
        .alu_cout  (alu_cout),
        .carry_we  (carry_we),
        .rd        (rd),
        .rd_we     (rd_we),
        .carry_q   (carry_q),
        .zero_q    (zero_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_we    (out_we)
`ifdef ALU_RESULT_FWD_EN
        ,
        .fwd_valid (fwd_valid),
        .fwd_rd    (fwd_rd),
        .fwd_data  (fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   pass_cnt  = 0;
    int   total_cnt = 0;

    ent_t model_q[$];   // contents the stage should be holding, oldest first
    ent_t sb_q[$];      // expected writeback order
    logic m_carry = 1'b0;
    logic m_zero  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: writeback consumes the head when out_valid && out_ready.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                total_cnt++;
                $display("FAIL sb_unexpected_pop: got data %0h with no expected entry", out_data);
            end else begin
                ent_t e;
                e = sb_q.pop_front();
                chk("pop_data", {24'd0, out_data}, {24'd0, e.d});
                chk("pop_rd",   {29'd0, out_rd},   {29'd0, e.r});
                chk("pop_we",   {31'd0, out_we},   {31'd0, e.w});
            end
        end
    end

    // Status checks against the model after every edge.
    task automatic check_status();
        chk("in_ready",  {31'd0, in_ready},  {31'd0, (model_q.size() < 2)});
        chk("out_valid", {31'd0, out_valid}, {31'd0, (model_q.size() > 0)});
        chk("carry_q",   {31'd0, carry_q},   {31'd0, m_carry});
        chk("zero_q",    {31'd0, zero_q},    {31'd0, m_zero});
        if (model_q.size() == 0) begin
            chk("empty_out_fields", {20'd0, out_data, out_rd, out_we}, 32'd0);
        end
`ifdef ALU_RESULT_FWD_EN
        begin
            logic       ev;
            logic [2:0] er;
            logic [7:0] ed;
            ev = 1'b0; er = 3'd0; ed = 8'h00;
            for (int i = model_q.size() - 1; i >= 0; i--) begin
                if (!ev && model_q[i].w) begin
                    ev = 1'b1; er = model_q[i].r; ed = model_q[i].d;
                end
            end
            chk("fwd", {20'd0, fwd_valid, fwd_rd, fwd_data}, {20'd0, ev, er, ed});
        end
`endif
    endtask

    // One clock cycle: drive inputs, predict acceptance, advance the model.
    task automatic cyc(input logic rst, input logic iv, input logic [7:0] d,
                       input logic z, input logic co, input logic cwe,
                       input logic [2:0] r, input logic w, input logic ordy);
        logic acc;
        logic pop;
        ent_t e;
        reset    = rst;
        in_valid = iv;
        alu_out  = d;
        alu_zero = z;
        alu_cout = co;
        carry_we = cwe;
        rd       = r;
        rd_we    = w;
        out_ready = ordy;
        acc = iv && (model_q.size() < 2);
        pop = ordy && (model_q.size() > 0);
        e.d = d; e.r = r; e.w = w;
        if (acc) sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (rst) begin
            model_q.delete();
            sb_q.delete();
            m_carry = 1'b0;
            m_zero  = 1'b0;
        end else begin
            if (pop) void'(model_q.pop_front());
            if (acc) begin
                model_q.push_back(e);
                if (cwe) m_carry = co;
                m_zero = z;
            end
        end
        check_status();
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, ordy);
    endtask

    task automatic push(input logic [7:0] d, input logic [2:0] r, input logic w, input logic ordy);
        cyc(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0, r, w, ordy);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; alu_out = 8'h00; alu_zero = 1'b0;
        alu_cout = 1'b0; carry_we = 1'b0; rd = 3'd0; rd_we = 1'b0; out_ready = 1'b0;

        // Reset state
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);

        // Single push with out_ready high: no bypass, visible next cycle
        push(8'h5A, 3'd3, 1'b1, 1'b1);
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_data",  {24'd0, out_data},  32'h5A);
        chk("lat_rd",    {29'd0, out_rd},    32'd3);
        idle(1'b1);
        chk("lat_drained", {31'd0, out_valid}, 32'd0);

        // Fill with out_ready low; third push must be refused
        push(8'h01, 3'd1, 1'b1, 1'b0);
        push(8'h02, 3'd2, 1'b1, 1'b0);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        push(8'h03, 3'd4, 1'b1, 1'b0);
        chk("full_head_hold", {24'd0, out_data}, 32'h01);
        idle(1'b1);
        chk("full_second", {24'd0, out_data}, 32'h02);
        idle(1'b1);
        chk("full_drained", {31'd0, out_valid}, 32'd0);

        // Simultaneous push and pop at count 1
        push(8'h11, 3'd1, 1'b1, 1'b0);
        push(8'h77, 3'd7, 1'b1, 1'b1);
        chk("pp_data",  {24'd0, out_data}, 32'h77);
        chk("pp_count1", {30'd0, out_valid, in_ready}, 32'd3);
        idle(1'b1);

        // Carry held when carry_we = 0; zero follows last accept
        cyc(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1);
        chk("carry_hold", {31'd0, carry_q}, 32'd1);
        chk("zero_last",  {31'd0, zero_q},  32'd0);
        idle(1'b1);

        // Reset wins over push and pop while full
        push(8'hA1, 3'd1, 1'b1, 1'b0);
        push(8'hA2, 3'd2, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1);
        chk("rstpri_valid", {31'd0, out_valid}, 32'd0);
        chk("rstpri_carry", {31'd0, carry_q},   32'd0);
        chk("rstpri_ready", {31'd0, in_ready},  32'd1);

`ifdef ALU_RESULT_FWD_EN
        push(8'h10, 3'd2, 1'b1, 1'b0);
        push(8'h20, 3'd5, 1'b0, 1'b0);
        chk("fwd_dir", {20'd0, fwd_valid, fwd_rd, fwd_data}, {20'd0, 1'b1, 3'd2, 8'h10});
        idle(1'b1);
        idle(1'b1);
`endif

        // Randomized traffic with occasional reset
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 39) == 0),
                ($urandom_range(0, 3) != 0),
                8'($urandom),
                1'($urandom),
                1'($urandom),
                1'($urandom),
                3'($urandom),
                1'($urandom),
                ($urandom_range(0, 2) != 0));
        end

        // Drain and confirm every expected entry was consumed
        for (int n = 0; n < 4; n++) idle(1'b1);
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
